zsdram_port_arbiter: RTL
========================

// Module: zsdram_port_arbiter
// PURPOSE
//  Shares the single 4-word SDRAM read/write glue port between two requesters:
//  M0 = LCD GRAM scan-out reader (read-only), M1 = shift/draw engine (read+write).
//  Sits between the requesters and the SDRAM controller.
//  Serializes accesses, gives M0 priority with a bounded-starvation guarantee for M1,
//  and routes done pulses and read data back to the owner.
// PARAMETERS
//  STARVE_LIMIT   4     consecutive M0 grants allowed while M1 is pending; the next grant goes to M1
//  TIMEOUT_CYC    4096  cycles a granted access may wait for controller done before abort
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   asynchronous active-low reset
//  en             in   1   1 = new grants allowed; 0 = finish current access, then hold IDLE
//  m0_rd_req      in   1   M0 read request, level, held until m0_rd_done
//  m0_rd_addr     in   24  M0 address, Bank(2)+Row(13)+Col(9), 4-word aligned
//  m0_rd_data     out  64  {w4,w3,w2,w1} read data, valid while m0_rd_done=1
//  m0_rd_done     out  1   one-cycle completion pulse to M0
//  m1_rd_req      in   1   M1 read request, level
//  m1_rd_addr     in   24  M1 read address
//  m1_rd_data     out  64  M1 read data, valid while m1_rd_done=1
//  m1_rd_done     out  1   one-cycle pulse
//  m1_wr_req      in   1   M1 write request, level
//  m1_wr_addr     in   24  M1 write address
//  m1_wr_data     in   64  {w4,w3,w2,w1} write data, stable while m1_wr_req=1
//  m1_wr_done     out  1   one-cycle pulse
//  sd_rd_req      out  1   to controller: read request
//  sd_rd_addr     out  24  to controller: read address
//  sd_rd_data     in   64  from controller: {Data4..Data1}
//  sd_rd_done     in   1   from controller: read done
//  sd_wr_req      out  1   to controller: write request
//  sd_wr_addr     out  24  to controller: write address
//  sd_wr_data     out  64  to controller: {Data4..Data1}
//  sd_wr_done     in   1   from controller: write done
//  busy           out  1   1 whenever state != IDLE
//  timeout_err    out  1   sticky; set on any abort; cleared only by reset
// BEHAVIOUR
//  Reset values
//  - All outputs are 0; state=IDLE; starve_cnt=0; timeout counter=0.
//  States: IDLE -> GRANT -> DONE -> IDLE.
//  IDLE, arbitration (only when en=1)
//  - Any req high: latch owner, op, addr and wr_data; go to GRANT.
//  - Next cycle: sd_rd_req or sd_wr_req=1 with the latched address/data (1-cycle request latency).
//  - Winner selection:
//    - M0 wins if m0_rd_req=1, unless M1 has a request pending and starve_cnt==STARVE_LIMIT; then M1 wins.
//    - M1 with both m1_wr_req and m1_rd_req high: write first.
//  - starve_cnt: +1 on each M0 grant while M1 is pending; 0 on any M1 grant or when M1 is idle; saturates.
//  GRANT
//  - sd_*_req held high, addr/data held constant from the latched values (requester changes are ignored).
//  - sd_*_done=1 at edge t:
//    - at t+1: sd_*_req=0; owner done=1 for exactly one cycle; rd_data registered from sd_rd_data (sampled at t).
//    - state=DONE.
//  - Done of the opposite type (e.g. sd_wr_done during a read) is ignored.
//  - Timeout counter counts GRANT cycles. On reaching TIMEOUT_CYC:
//    - drop sd_*_req; pulse owner done; rd_data=0; set timeout_err; go to DONE.
//  DONE
//  - One cycle; all req inputs ignored, so the owner can deassert. Then IDLE.
//  - Back-to-back grants: min 3 cycles/access excluding controller time.
//  - Non-owner data outputs hold last value; only the owner's done pulses.
//  en deasserted mid-access: current access completes normally; no new grant.
//  Async reset mid-access: outputs 0 at once; controller req drops; no done is issued.
// TESTING
//  T1: m0_rd_req only, addr=0x05DC00; ctrl done 5 cycles after req
//      -> sd_rd_addr=0x05DC00, 1 m0_rd_done pulse, data=ctrl data, m1 dones=0.
//  T2: m0 and m1_wr held continuously, STARVE_LIMIT=4
//      -> grant order M0,M0,M0,M0,M1,M0..., m1_wr_done each 5th access.
//  T3: m1_rd and m1_wr asserted same cycle -> write (sd_wr_data=m1_wr_data) granted before read.
//  T4: sd done never arrives, TIMEOUT_CYC=16
//      -> req drops after 16 GRANT cycles, owner done pulses, timeout_err=1 and sticky.
//  T5: en=0 during GRANT with m0 pending -> current access finishes; no new sd req until en=1.
//  T6: rst_n low mid-GRANT -> sd_rd_req=0 immediately; no done pulse; IDLE after release.

Source files
------------

// File: rtl/zsdram_port_arbiter.sv
// Two-requester arbiter in front of the 4-word SDRAM glue port: M0 (scan-out reads)
// has priority, M1 (draw engine) is guaranteed a grant after STARVE_LIMIT M0 wins.
module zsdram_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        m0_rd_req,
    input  logic [23:0] m0_rd_addr,
    output logic [63:0] m0_rd_data,
    output logic        m0_rd_done,
    input  logic        m1_rd_req,
    input  logic [23:0] m1_rd_addr,
    output logic [63:0] m1_rd_data,
    output logic        m1_rd_done,
    input  logic        m1_wr_req,
    input  logic [23:0] m1_wr_addr,
    input  logic [63:0] m1_wr_data,
    output logic        m1_wr_done,
    output logic        sd_rd_req,
    output logic [23:0] sd_rd_addr,
    input  logic [63:0] sd_rd_data,
    input  logic        sd_rd_done,
    output logic        sd_wr_req,
    output logic [23:0] sd_wr_addr,
    output logic [63:0] sd_wr_data,
    input  logic        sd_wr_done,
    output logic        busy,
    output logic        timeout_err
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic            m1_owner_r, m1_owner_s;
    logic            wr_op_r, wr_op_s;
    logic [SW-1:0]   starve_cnt_r, starve_cnt_s;
    logic [TW-1:0]   tmo_cnt_r, tmo_cnt_s;
    logic            sd_rd_req_r, sd_rd_req_s;
    logic            sd_wr_req_r, sd_wr_req_s;
    logic [23:0]     sd_rd_addr_r, sd_rd_addr_s;
    logic [23:0]     sd_wr_addr_r, sd_wr_addr_s;
    logic [63:0]     sd_wr_data_r, sd_wr_data_s;
    logic [63:0]     m0_rd_data_r, m0_rd_data_s;
    logic [63:0]     m1_rd_data_r, m1_rd_data_s;
    logic            m0_rd_done_r, m0_rd_done_s;
    logic            m1_rd_done_r, m1_rd_done_s;
    logic            m1_wr_done_r, m1_wr_done_s;
    logic            busy_r, busy_s;
    logic            timeout_err_r, timeout_err_s;

    logic            m1_pend_s;
    logic            m0_wins_s;
    logic            done_hit_s;
    logic            tmo_hit_s;

    // Saturating increment of the starvation counter.
    function automatic logic [SW-1:0] starve_inc(input logic [SW-1:0] cnt);
        if (cnt == SW'(STARVE_LIMIT)) begin
            starve_inc = cnt;
        end else begin
            starve_inc = cnt + SW'(1);
        end
    endfunction

    // Arbitration decision and completion detection.
    always_comb begin
        m1_pend_s  = m1_rd_req | m1_wr_req;
        m0_wins_s  = m0_rd_req & ~(m1_pend_s & (starve_cnt_r == SW'(STARVE_LIMIT)));
        done_hit_s = wr_op_r ? sd_wr_done : sd_rd_done;
        tmo_hit_s  = (tmo_cnt_r == TW'(TIMEOUT_CYC - 1));
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_s       = state_r;
        m1_owner_s    = m1_owner_r;
        wr_op_s       = wr_op_r;
        starve_cnt_s  = starve_cnt_r;
        tmo_cnt_s     = tmo_cnt_r;
        sd_rd_req_s   = sd_rd_req_r;
        sd_wr_req_s   = sd_wr_req_r;
        sd_rd_addr_s  = sd_rd_addr_r;
        sd_wr_addr_s  = sd_wr_addr_r;
        sd_wr_data_s  = sd_wr_data_r;
        m0_rd_data_s  = m0_rd_data_r;
        m1_rd_data_s  = m1_rd_data_r;
        m0_rd_done_s  = 1'b0;
        m1_rd_done_s  = 1'b0;
        m1_wr_done_s  = 1'b0;
        timeout_err_s = timeout_err_r;

        case (state_r)
            ST_IDLE: begin
                if (en && (m0_rd_req || m1_pend_s)) begin
                    state_s   = ST_GRANT;
                    tmo_cnt_s = '0;
                    if (m0_wins_s) begin
                        m1_owner_s   = 1'b0;
                        wr_op_s      = 1'b0;
                        sd_rd_req_s  = 1'b1;
                        sd_rd_addr_s = m0_rd_addr;
                        starve_cnt_s = m1_pend_s ? starve_inc(starve_cnt_r) : '0;
                    end else if (m1_wr_req) begin
                        m1_owner_s   = 1'b1;
                        wr_op_s      = 1'b1;
                        sd_wr_req_s  = 1'b1;
                        sd_wr_addr_s = m1_wr_addr;
                        sd_wr_data_s = m1_wr_data;
                        starve_cnt_s = '0;
                    end else begin
                        m1_owner_s   = 1'b1;
                        wr_op_s      = 1'b0;
                        sd_rd_req_s  = 1'b1;
                        sd_rd_addr_s = m1_rd_addr;
                        starve_cnt_s = '0;
                    end
                end else if (!m1_pend_s) begin
                    starve_cnt_s = '0;
                end else begin
                    starve_cnt_s = starve_cnt_r;
                end
            end

            ST_GRANT: begin
                // A controller done wins over a timeout landing on the same edge.
                if (done_hit_s || tmo_hit_s) begin
                    state_s     = ST_DONE;
                    tmo_cnt_s   = '0;
                    sd_rd_req_s = 1'b0;
                    sd_wr_req_s = 1'b0;
                    if (!done_hit_s) begin
                        timeout_err_s = 1'b1;
                    end else begin
                        timeout_err_s = timeout_err_r;
                    end
                    if (!m1_owner_r) begin
                        m0_rd_done_s = 1'b1;
                        m0_rd_data_s = done_hit_s ? sd_rd_data : 64'd0;
                    end else if (wr_op_r) begin
                        m1_wr_done_s = 1'b1;
                    end else begin
                        m1_rd_done_s = 1'b1;
                        m1_rd_data_s = done_hit_s ? sd_rd_data : 64'd0;
                    end
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TW'(1);
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
            end

            default: begin
                state_s     = ST_IDLE;
                sd_rd_req_s = 1'b0;
                sd_wr_req_s = 1'b0;
                tmo_cnt_s   = '0;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            m1_owner_r    <= 1'b0;
            wr_op_r       <= 1'b0;
            starve_cnt_r  <= '0;
            tmo_cnt_r     <= '0;
            sd_rd_req_r   <= 1'b0;
            sd_wr_req_r   <= 1'b0;
            sd_rd_addr_r  <= 24'd0;
            sd_wr_addr_r  <= 24'd0;
            sd_wr_data_r  <= 64'd0;
            m0_rd_data_r  <= 64'd0;
            m1_rd_data_r  <= 64'd0;
            m0_rd_done_r  <= 1'b0;
            m1_rd_done_r  <= 1'b0;
            m1_wr_done_r  <= 1'b0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            m1_owner_r    <= m1_owner_s;
            wr_op_r       <= wr_op_s;
            starve_cnt_r  <= starve_cnt_s;
            tmo_cnt_r     <= tmo_cnt_s;
            sd_rd_req_r   <= sd_rd_req_s;
            sd_wr_req_r   <= sd_wr_req_s;
            sd_rd_addr_r  <= sd_rd_addr_s;
            sd_wr_addr_r  <= sd_wr_addr_s;
            sd_wr_data_r  <= sd_wr_data_s;
            m0_rd_data_r  <= m0_rd_data_s;
            m1_rd_data_r  <= m1_rd_data_s;
            m0_rd_done_r  <= m0_rd_done_s;
            m1_rd_done_r  <= m1_rd_done_s;
            m1_wr_done_r  <= m1_wr_done_s;
            busy_r        <= busy_s;
            timeout_err_r <= timeout_err_s;
        end
    end

    assign sd_rd_req   = sd_rd_req_r;
    assign sd_wr_req   = sd_wr_req_r;
    assign sd_rd_addr  = sd_rd_addr_r;
    assign sd_wr_addr  = sd_wr_addr_r;
    assign sd_wr_data  = sd_wr_data_r;
    assign m0_rd_data  = m0_rd_data_r;
    assign m1_rd_data  = m1_rd_data_r;
    assign m0_rd_done  = m0_rd_done_r;
    assign m1_rd_done  = m1_rd_done_r;
    assign m1_wr_done  = m1_wr_done_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_err_r;

endmodule
